// File: rtl/dmem_map_pkg.sv
// Address map, register offsets and status bit positions for the
// data-memory / MMIO responder.
package dmem_map_pkg;

    localparam logic [15:0] RAM_REGION = 16'h0000;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;

    localparam logic [15:0] MMIO_CYCLE_OFF  = 16'h0000;
    localparam logic [15:0] MMIO_TCMP_OFF   = 16'h0004;
    localparam logic [15:0] MMIO_TSTAT_OFF  = 16'h0008;
    localparam logic [15:0] MMIO_TXDATA_OFF = 16'h000C;
    localparam logic [15:0] MMIO_TXSTAT_OFF = 16'h0010;

    localparam int MMIO_TSTAT_PEND_BIT = 0;
    localparam int MMIO_TX_FULL_BIT    = 0;
    localparam int MMIO_TX_EMPTY_BIT   = 1;
    localparam int MMIO_TX_OVF_BIT     = 2;
    localparam int MMIO_TX_COUNT_LSB   = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CYCLE,
        SEL_TCMP,
        SEL_TSTAT,
        SEL_TXDATA,
        SEL_TXSTAT
    } sel_e;

    // Word address in, target out; RAM words past the array map to nothing.
    function automatic sel_e decode_addr(
        input logic [31:2] wa,
        input int          depth_words
    );
        sel_e s;
        s = SEL_NONE;
        if (wa[31:16] == RAM_REGION) begin
            if ({1'b0, wa[15:2]} < 15'(depth_words))
                s = SEL_RAM;
        end else if (wa[31:16] == MMIO_BASE[31:16]) begin
            case ({wa[15:2], 2'b00})
                MMIO_CYCLE_OFF:  s = SEL_CYCLE;
                MMIO_TCMP_OFF:   s = SEL_TCMP;
                MMIO_TSTAT_OFF:  s = SEL_TSTAT;
                MMIO_TXDATA_OFF: s = SEL_TXDATA;
                MMIO_TXSTAT_OFF: s = SEL_TXSTAT;
                default:         s = SEL_NONE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus MMIO cycle counter, compare
// timer and byte TX FIFO.
module dmem_mmio_responder
    import dmem_map_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        timer_irq
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sel_e          sel;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_q [DEPTH_WORDS];

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        pend_q, pend_d;
    logic        ovf_q, ovf_d;

    logic          ram_we, tcmp_we, tstat_we, txdata_we, txstat_we;
    logic          tx_full, tx_empty, tx_pop;
    logic [CW-1:0] tx_count;
    logic [7:0]    tx_head;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr[1:0];

    assign sel       = decode_addr(addr[31:2], DEPTH_WORDS);
    assign ram_idx   = addr[AW+1:2];
    assign ram_we    = memwrite && (sel == SEL_RAM);
    assign tcmp_we   = memwrite && (sel == SEL_TCMP);
    assign tstat_we  = memwrite && (sel == SEL_TSTAT);
    assign txdata_we = memwrite && (sel == SEL_TXDATA);
    assign txstat_we = memwrite && (sel == SEL_TXSTAT);

    assign out_valid = !tx_empty;
    assign out_data  = tx_head;
    assign tx_pop    = out_valid && out_ready;
    assign timer_irq = pend_q;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (txdata_we),
        .push_data (writedata[7:0]),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .head      (tx_head)
    );

    always_ff @(posedge clk) begin
        if (ram_we)
            ram_q[ram_idx] <= writedata;
    end

    // Priority: TSTAT clear < compare match < TCMP write.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        tcmp_d  = tcmp_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        if (tstat_we && writedata[MMIO_TSTAT_PEND_BIT])
            pend_d = 1'b0;
        if (cycle_q == tcmp_q)
            pend_d = 1'b1;
        if (tcmp_we) begin
            tcmp_d = writedata;
            pend_d = 1'b0;
        end
        if (txstat_we)
            ovf_d = 1'b0;
        if (txdata_we && tx_full && !tx_pop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            tcmp_q  <= 32'hFFFF_FFFF;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            tcmp_q  <= tcmp_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        readdata = '0;
        unique case (sel)
            SEL_RAM:   readdata = ram_q[ram_idx];
            SEL_CYCLE: readdata = cycle_q;
            SEL_TCMP:  readdata = tcmp_q;
            SEL_TSTAT: readdata[MMIO_TSTAT_PEND_BIT] = pend_q;
            SEL_TXSTAT: begin
                readdata[MMIO_TX_FULL_BIT]  = tx_full;
                readdata[MMIO_TX_EMPTY_BIT] = tx_empty;
                readdata[MMIO_TX_OVF_BIT]   = ovf_q;
                readdata[MMIO_TX_COUNT_LSB +: CW] = tx_count;
            end
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized self-checking bench for dmem_mmio_responder with a
// queue/array reference model.
module tb_dmem_mmio_responder;

    localparam int DW = 256;
    localparam int FD = 4;
    localparam logic [31:0] A_CYC = 32'hFFFF_0000;
    localparam logic [31:0] A_TCMP = 32'hFFFF_0004;
    localparam logic [31:0] A_TST = 32'hFFFF_0008;
    localparam logic [31:0] A_TXD = 32'hFFFF_000C;
    localparam logic [31:0] A_TXS = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;
    int unsigned edges = 0;

    dmem_mmio_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .readdata(readdata),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Reference cycle count: edges seen since reset was released.
    always @(posedge clk or posedge reset)
        if (reset) edges = 0;
        else edges = edges + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; writedata = d; memwrite = 1'b1;
        cyc();
        memwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        memwrite = 1'b0; addr = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_cycle(input int unsigned t, output bit ok);
        int n = 0;
        while (edges != t && n < 200) begin
            cyc();
            n++;
        end
        ok = (edges == t);
    endtask

    function automatic logic [31:0] txstat(input int n, input bit ovf);
        logic [31:0] r;
        r = '0;
        r[0] = (n == FD);
        r[1] = (n == 0);
        r[2] = ovf;
        r[15:8] = n[7:0];
        return r;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if (out_valid !== 1'b0 || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: valid=%b irq=%b want 0 0", out_valid, timer_irq);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rd(A_CYC, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL reset_cycle: got %h want 0", d);
        end
        rd(A_TCMP, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_tcmp: got %h want ffffffff", d);
        end
        rd(A_TST, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL reset_tstat: got %h want 0", d);
        end
        rd(A_TXS, d);
        checks++;
        if (d !== txstat(0, 1'b0)) begin
            errors++; $display("FAIL reset_txstat: got %h want %h", d, txstat(0, 1'b0));
        end
    endtask

    task automatic test_counter();
        logic [31:0] d;
        repeat (10) cyc();
        rd(A_CYC, d);
        checks++;
        if (d !== 32'd10) begin
            errors++; $display("FAIL cycle_10: got %h want 0000000a", d);
        end
        repeat ($urandom_range(3, 20)) cyc();
        rd(A_CYC, d);
        checks++;
        if (d !== edges) begin
            errors++; $display("FAIL cycle_track: got %h want %h", d, edges);
        end
    endtask

    task automatic test_ram();
        logic [31:0] m [DW];
        bit          w [DW];
        logic [31:0] d, a, v;
        int          idx;
        for (int i = 0; i < DW; i++) w[i] = 1'b0;
        wr(32'h0000_0000, 32'h1234_5678);
        wr(32'h0000_0040, 32'hDEAD_BEEF);
        m[0] = 32'h1234_5678; w[0] = 1'b1;
        m[16] = 32'hDEAD_BEEF; w[16] = 1'b1;
        rd(32'h0000_0040, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_40: got %h want deadbeef", d);
        end
        rd(32'h0000_0043, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_43: got %h want deadbeef", d);
        end
        rd(32'h0000_0400, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL ram_oob_rd: got %h want 0", d);
        end
        wr(32'h0000_0400, 32'hCAFE_F00D);
        wr(32'h0001_0040, 32'h1111_1111);
        rd(32'h0000_0000, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_oob_wr: word0 %h want 12345678", d);
        end
        rd(32'h0000_0040, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_other_wr: word16 %h want deadbeef", d);
        end
        rd(32'h0001_0040, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL unmapped_rd: got %h want 0", d);
        end
        for (int it = 0; it < 160; it++) begin
            idx = $urandom_range(0, DW - 1);
            a = (idx * 4) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                wr(a, v);
                m[idx] = v; w[idx] = 1'b1;
            end else if (w[idx]) begin
                rd(a, d);
                checks++;
                if (d !== m[idx]) begin
                    errors++;
                    $display("FAIL ram_rand: addr %h got %h want %h", a, d, m[idx]);
                end
                cyc();
            end
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        int unsigned t;
        bit ok;
        t = edges + 8;
        wr(A_TCMP, t);
        wait_cycle(t, ok);
        checks++;
        if (!ok || timer_irq !== 1'b0) begin
            errors++; $display("FAIL irq_before: ok=%b irq=%b want 1 0", ok, timer_irq);
        end
        cyc();
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++; $display("FAIL irq_rise: irq=%b want 1", timer_irq);
        end
        rd(A_TST, d);
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("FAIL tstat_pend: got %h want 1", d);
        end
        wr(A_TST, 32'h2);
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++; $display("FAIL tstat_bit0_zero: irq=%b want 1", timer_irq);
        end
        wr(A_TST, 32'h1);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL tstat_clear: irq=%b want 0", timer_irq);
        end
        t = edges + 6;
        wr(A_TCMP, t);
        wait_cycle(t, ok);
        wr(A_TST, 32'h1);
        checks++;
        if (!ok || timer_irq !== 1'b1) begin
            errors++; $display("FAIL match_vs_clear: ok=%b irq=%b want 1 1", ok, timer_irq);
        end
        wr(A_TST, 32'h1);
        t = edges + 6;
        wr(A_TCMP, t);
        wait_cycle(t, ok);
        wr(A_TCMP, 32'hFFFF_FFFF);
        repeat (2) cyc();
        rd(A_TCMP, d);
        checks++;
        if (!ok || timer_irq !== 1'b0 || d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL match_vs_tcmp: ok=%b irq=%b tcmp=%h want 1 0 ffffffff", ok, timer_irq, d);
        end
    endtask

    task automatic test_fifo();
        logic [31:0] d;
        logic [7:0]  got [$];
        logic [7:0]  exp [$];
        bit          stable;
        int          n;
        out_ready = 1'b0;
        exp = '{8'h41, 8'h42, 8'h43, 8'h44};
        foreach (exp[i]) wr(A_TXD, {24'h0, exp[i]});
        rd(A_TXS, d);
        checks++;
        if (d !== txstat(4, 1'b0)) begin
            errors++; $display("FAIL fifo_full_stat: got %h want %h", d, txstat(4, 1'b0));
        end
        wr(A_TXD, 32'h45);
        rd(A_TXS, d);
        checks++;
        if (d !== txstat(4, 1'b1)) begin
            errors++; $display("FAIL fifo_ovf_stat: got %h want %h", d, txstat(4, 1'b1));
        end
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'h41) stable = 1'b0;
            cyc();
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL fifo_hold: head=%h valid=%b want 41 1", out_data, out_valid);
        end
        out_ready = 1'b1;
        n = 0;
        while (out_valid === 1'b1 && n < 20) begin
            got.push_back(out_data);
            cyc();
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (got != exp) begin
            errors++; $display("FAIL fifo_order: got %p want %p", got, exp);
        end
        rd(A_TXS, d);
        checks++;
        if (out_valid !== 1'b0 || d !== txstat(0, 1'b1)) begin
            errors++; $display("FAIL fifo_drained: valid=%b stat=%h want 0 %h", out_valid, d, txstat(0, 1'b1));
        end
        wr(A_TXS, 32'h0);
        rd(A_TXS, d);
        checks++;
        if (d !== txstat(0, 1'b0)) begin
            errors++; $display("FAIL ovf_clear: got %h want %h", d, txstat(0, 1'b0));
        end
        addr = A_TXD; writedata = 32'h77; memwrite = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL no_bypass: valid=%b want 0", out_valid);
        end
        cyc();
        memwrite = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            errors++; $display("FAIL push_empty: valid=%b data=%h want 1 77", out_valid, out_data);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  got [$];
        logic [7:0]  exp [$];
        int          n;
        for (int i = 0; i < 4; i++) wr(A_TXD, 32'h12 + i);
        addr = A_TXD; writedata = 32'h55; memwrite = 1'b1; out_ready = 1'b1;
        cyc();
        memwrite = 1'b0; out_ready = 1'b0;
        rd(A_TXS, d);
        checks++;
        if (d !== txstat(4, 1'b0)) begin
            errors++; $display("FAIL full_push_pop: stat %h want %h", d, txstat(4, 1'b0));
        end
        exp = '{8'h13, 8'h14, 8'h15, 8'h55};
        out_ready = 1'b1;
        n = 0;
        while (out_valid === 1'b1 && n < 20) begin
            got.push_back(out_data);
            cyc();
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (got != exp) begin
            errors++; $display("FAIL full_push_pop_order: got %p want %p", got, exp);
        end
    endtask

    task automatic test_random_fifo();
        logic [7:0] q [$];
        bit         ovf = 1'b0;
        bit         pop;
        int         op;
        logic [7:0] b;
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            b = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 4);
            memwrite = (op <= 5);
            writedata = {24'($urandom), b};
            addr = (op == 5) ? A_TXS : (op < 5 ? A_TXD : A_TXS);
            #1;
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid: it %0d got %b want %b", it, out_valid, q.size() != 0);
            end else if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++; $display("FAIL rnd_head: it %0d got %h want %h", it, out_data, q[0]);
                end
            end
            if (op > 5) begin
                checks++;
                if (readdata !== txstat(q.size(), ovf)) begin
                    errors++;
                    $display("FAIL rnd_txstat: it %0d got %h want %h", it, readdata, txstat(q.size(), ovf));
                end
            end else if (op < 5) begin
                checks++;
                if (readdata !== 32'd0) begin
                    errors++; $display("FAIL rnd_txdata_rd: got %h want 0", readdata);
                end
            end
            pop = (q.size() != 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (op < 5) begin
                if (q.size() < FD) q.push_back(b);
                else ovf = 1'b1;
            end
            if (op == 5) ovf = 1'b0;
            cyc();
        end
        memwrite = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int unsigned t;
        bit ok;
        int n = 0;
        out_ready = 1'b1;
        while (out_valid === 1'b1 && n < 20) begin cyc(); n++; end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_TXD, 32'h60 + i);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        t = edges + 4;
        wr(A_TCMP, t);
        wait_cycle(t, ok);
        cyc();
        rd(A_TXS, d);
        checks++;
        if (!ok || timer_irq !== 1'b1 || d !== txstat(3, 1'b1)) begin
            errors++;
            $display("FAIL pre_reset: ok=%b irq=%b stat=%h want 1 1 %h", ok, timer_irq, d, txstat(3, 1'b1));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || timer_irq !== 1'b0 || readdata !== txstat(0, 1'b0)) begin
            errors++;
            $display("FAIL async_reset: valid=%b irq=%b stat=%h want 0 0 %h", out_valid, timer_irq, readdata, txstat(0, 1'b0));
        end
        @(posedge clk);
        #2 reset = 1'b0;
        rd(A_CYC, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL cycle_after_reset: got %h want 0", d);
        end
        repeat (3) cyc();
        rd(A_CYC, d);
        checks++;
        if (d !== 32'd3) begin
            errors++; $display("FAIL cycle_restart: got %h want 3", d);
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_ram();
        test_timer();
        test_fifo();
        test_back_to_back();
        test_random_fifo();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
